// File: rtl/requests_pc_dispatcher_if.sv
// Request-word bus between the PC register bank and the dispatcher.
//   rqst_data  : command word
//   rqst_valid : one-cycle write strobe qualifying rqst_data
//   rqst_ack   : one-cycle pulse per accepted word
// master = PC register side, slave = dispatcher.
interface requests_pc_dispatcher_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] rqst_data;
  logic                  rqst_valid;
  logic                  rqst_ack;

  modport master (output rqst_data, output rqst_valid, input rqst_ack);
  modport slave  (input rqst_data, input rqst_valid, output rqst_ack);
endinterface

// File: rtl/requests_pc_dispatcher.sv
// Decodes PC command words into control pulses, a run level, a timed module
// reset and held per-channel / trigger-status requests.
//   clk, rst            : clock, synchronous active-high reset
//   rqst                : request bus (slave side)
//   start_o, conf_o     : one-cycle pulses
//   reset_o, busy_o     : high for RESET_CYCLES while in the reset state
//   running_o           : run level
//   rqst_ch_o / _ack_i  : per-channel held requests and acknowledges
//   rqst_ts_o / _ack_i  : trigger-status held request and acknowledge
//   overrun_o           : sticky, a request was lost
module requests_pc_dispatcher #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned RESET_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  requests_pc_dispatcher_if.slave rqst,
  output logic                 start_o,
  output logic                 conf_o,
  output logic                 reset_o,
  output logic                 running_o,
  output logic                 busy_o,
  output logic [NUM_CH-1:0]    rqst_ch_o,
  input  logic [NUM_CH-1:0]    rqst_ch_ack_i,
  output logic                 rqst_ts_o,
  input  logic                 rqst_ts_ack_i,
  output logic                 overrun_o
);

  localparam int unsigned CntW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StReset} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0] ch_q, ch_d, ch_new;
  logic              ts_q, ts_d, ts_new;
  logic              ack_q, start_q, conf_q, overrun_q, overrun_d;

  logic accept, drop;
  logic w_start, w_reset, w_stop, w_conf, w_ts;

  // Bits above the channel field are ignored by design.
  logic unused_data;
  assign unused_data = ^rqst.rqst_data;

  assign accept  = rqst.rqst_valid && (state_q != StReset);
  assign drop    = rqst.rqst_valid && (state_q == StReset);
  assign w_start = rqst.rqst_data[0];
  assign w_reset = rqst.rqst_data[1];
  assign w_stop  = rqst.rqst_data[2];
  assign w_conf  = rqst.rqst_data[3];
  assign w_ts    = rqst.rqst_data[4];

  // A reset word discards all its other bits.
  assign ch_new = (accept && !w_reset) ? rqst.rqst_data[5 +: NUM_CH] : '0;
  assign ts_new = accept && !w_reset && w_ts;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StReset: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      default: begin
        if (accept) begin
          if (w_reset) begin
            state_d = StReset;
            cnt_d   = CntLoad;
          end else if (w_stop) begin
            state_d = StIdle;
          end else if (w_start) begin
            state_d = StRun;
          end
        end
      end
    endcase
  end

  // State-decoded outputs (driven only by registers)
  always_comb begin
    running_o = (state_q == StRun);
    reset_o   = (state_q == StReset);
    busy_o    = (state_q == StReset);
  end

  // New request wins over a same-cycle ack; a repeat without ack is an overrun.
  always_comb begin
    if (accept && w_reset) begin
      ch_d = '0;
      ts_d = 1'b0;
    end else begin
      ch_d = (ch_q & ~rqst_ch_ack_i) | ch_new;
      ts_d = (ts_q & ~rqst_ts_ack_i) | ts_new;
    end
    overrun_d = overrun_q | drop | (|(ch_new & ch_q & ~rqst_ch_ack_i))
              | (ts_new & ts_q & ~rqst_ts_ack_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q     <= 1'b0;
      start_q   <= 1'b0;
      conf_q    <= 1'b0;
      ch_q      <= '0;
      ts_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ack_q     <= accept;
      start_q   <= accept && !w_reset && !w_stop && w_start;
      conf_q    <= accept && !w_reset && w_conf;
      ch_q      <= ch_d;
      ts_q      <= ts_d;
      overrun_q <= overrun_d;
    end
  end

  assign rqst.rqst_ack = ack_q;
  assign start_o       = start_q;
  assign conf_o        = conf_q;
  assign rqst_ch_o     = ch_q;
  assign rqst_ts_o     = ts_q;
  assign overrun_o     = overrun_q;

endmodule
